deser_rr_arbiter: RTL and testbench

DESER_RR_ARBITER -- requirements
Module: deser_rr_arbiter

---
 rtl/deser_arb_pkg.sv | 22 ++
 rtl/deser_rr_arbiter_rr_pick.sv | 36 +++
 rtl/deser_rr_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_deser_rr_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/deser_arb_pkg.sv
// Shared types and helpers for the deserializing round-robin arbiter.
// Holds the three-state FSM encoding and the channel-index width helper.
package deser_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned n_ch);
    int unsigned w;
    if (n_ch <= 32'd2) begin
      w = 32'd1;
    end else begin
      w = $clog2(n_ch);
    end
    return w;
  endfunction

endpackage

// File: rtl/deser_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: starting at ptr and wrapping modulo
// N_CH, selects the first requesting channel. Outputs a one-hot grant,
// the granted index and a flag that any channel is requesting.
module rr_pick #(
  parameter int unsigned N_CH = 32'd4,
  parameter int unsigned CH_W = 32'd2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] idx,
  output logic            any
);

  // Scan channels from ptr upward with wrap and keep the first requester
  always_comb begin
    logic [CH_W-1:0] cand;
    logic            found;
    logic            hit;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    hit   = 1'b0;
    cand  = '0;
    for (int unsigned i = 32'd0; i < N_CH; i++) begin
      cand      = CH_W'((32'(ptr) + i) % N_CH);
      hit       = ~found & req[cand];
      gnt[cand] = hit;
      idx       = hit ? cand : idx;
      found     = found | hit;
    end
  end

  assign any = |req;

endmodule

// File: rtl/deser_rr_arbiter.sv
// Deserializing round-robin arbiter. Grants one serial requester at a time,
// assembles DATA_W bits MSB first from the granted channel only, then emits
// the word with its source channel for one cycle.
// Optional feature macro: DESER_RR_ARBITER_TIMEOUT_EN -- aborts a grant after
// TIMEOUT_CYC consecutive cycles without a valid bit and pulses err_o.
module deser_rr_arbiter
  import deser_arb_pkg::*;
#(
  parameter  int unsigned N_CH        = 32'd4,
  parameter  int unsigned DATA_W      = 32'd16,
  parameter  int unsigned TIMEOUT_CYC = 32'd64,
  localparam int unsigned CH_W        = ch_width(N_CH)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [N_CH-1:0]   req_i,
  input  logic [N_CH-1:0]   data_i,
  input  logic [N_CH-1:0]   data_val_i,
  output logic [N_CH-1:0]   gnt_o,
  output logic [DATA_W-1:0] word_o,
  output logic [CH_W-1:0]   word_ch_o,
  output logic              word_val_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  state_e              state_q,    state_d;
  logic [CH_W-1:0]     rr_ptr_q,   rr_ptr_d;
  logic [CH_W-1:0]     gidx_q,     gidx_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [N_CH-1:0]     gnt_q,      gnt_d;
  logic [DATA_W-1:0]   shreg_q,    shreg_d;
  logic [DATA_W-1:0]   word_q,     word_d;
  logic [CH_W-1:0]     word_ch_q,  word_ch_d;
  logic                word_val_q, word_val_d;

  logic [N_CH-1:0]     pick_gnt_s;
  logic [CH_W-1:0]     pick_idx_s;
  logic                pick_any_s;

  logic                bit_s;
  logic                val_s;
  logic                req_s;
  logic                last_s;
  logic [CNT_W-1:0]    bit_pos_s;

`ifdef DESER_RR_ARBITER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 32'd1);
  logic [TO_W-1:0]     idle_q, idle_d;
  logic                err_q,  err_d;
`else
  logic                unused_timeout_s;
`endif

  rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_rr_pick (
    .req (req_i),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // Only the granted channel's lines are ever looked at
  assign bit_s     = data_i[gidx_q];
  assign val_s     = data_val_i[gidx_q];
  assign req_s     = req_i[gidx_q];
  assign last_s    = (cnt_q == CNT_W'(DATA_W - 32'd1));
  assign bit_pos_s = CNT_W'(DATA_W - 32'd1) - cnt_q;

  // Next-state, grant and word-assembly logic
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gidx_d     = gidx_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    shreg_d    = shreg_q;
    word_d     = word_q;
    word_ch_d  = word_ch_q;
    word_val_d = 1'b0;
`ifdef DESER_RR_ARBITER_TIMEOUT_EN
    idle_d     = idle_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          gnt_d    = pick_gnt_s;
          gidx_d   = pick_idx_s;
          rr_ptr_d = (pick_idx_s == CH_W'(N_CH - 32'd1)) ? '0 : pick_idx_s + CH_W'(1'b1);
          cnt_d    = '0;
`ifdef DESER_RR_ARBITER_TIMEOUT_EN
          idle_d   = '0;
`endif
          state_d  = COLLECT;
        end else begin
          state_d  = IDLE;
        end
      end
      COLLECT: begin
        if (val_s && last_s) begin
          // Final bit wins over a simultaneous request drop
          word_d            = shreg_q;
          word_d[bit_pos_s] = bit_s;
          word_ch_d         = gidx_q;
          word_val_d        = 1'b1;
          gnt_d             = '0;
          cnt_d             = '0;
          state_d           = EMIT;
        end else if (!req_s) begin
          // Requester withdrew: drop the partial word silently
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (val_s) begin
          shreg_d[bit_pos_s] = bit_s;
          cnt_d              = cnt_q + CNT_W'(1'b1);
`ifdef DESER_RR_ARBITER_TIMEOUT_EN
          idle_d             = '0;
`endif
        end else begin
`ifdef DESER_RR_ARBITER_TIMEOUT_EN
          if (idle_q == TO_W'(TIMEOUT_CYC - 32'd1)) begin
            err_d   = 1'b1;
            gnt_d   = '0;
            cnt_d   = '0;
            idle_d  = '0;
            state_d = IDLE;
          end else begin
            idle_d  = idle_q + TO_W'(1'b1);
          end
`else
          state_d = COLLECT;
`endif
        end
      end
      EMIT: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered-output flops
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      shreg_q    <= '0;
      word_q     <= '0;
      word_ch_q  <= '0;
      word_val_q <= 1'b0;
`ifdef DESER_RR_ARBITER_TIMEOUT_EN
      idle_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gidx_q     <= gidx_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      shreg_q    <= shreg_d;
      word_q     <= word_d;
      word_ch_q  <= word_ch_d;
      word_val_q <= word_val_d;
`ifdef DESER_RR_ARBITER_TIMEOUT_EN
      idle_q     <= idle_d;
      err_q      <= err_d;
`endif
    end
  end

  assign gnt_o      = gnt_q;
  assign word_o     = word_q;
  assign word_ch_o  = word_ch_q;
  assign word_val_o = word_val_q;

`ifdef DESER_RR_ARBITER_TIMEOUT_EN
  assign err_o = err_q;
`else
  // Without the timeout feature the error line is constant low
  assign err_o            = 1'b0;
  assign unused_timeout_s = (TIMEOUT_CYC == 32'd0);
`endif

endmodule

// File: tb/tb_deser_rr_arbiter.sv
// Self-checking bench for deser_rr_arbiter (N_CH=4, DATA_W=16, TIMEOUT_CYC=8).
// Expected words are queued when a transfer starts and popped by a monitor
// when word_val_o pulses.
module tb_deser_rr_arbiter;

  localparam int N_CH        = 4;
  localparam int DATA_W      = 16;
  localparam int TIMEOUT_CYC = 8;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] w;
  } exp_t;

  logic        clk_i      = 1'b0;
  logic        arst_i     = 1'b1;
  logic [3:0]  req_i      = 4'd0;
  logic [3:0]  data_i     = 4'd0;
  logic [3:0]  data_val_i = 4'd0;
  logic [3:0]  gnt_o;
  logic [15:0] word_o;
  logic [1:0]  word_ch_o;
  logic        word_val_o;
  logic        err_o;

  int   errors       = 0;
  int   checks       = 0;
  int   words_pushed = 0;
  int   words_seen   = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [1:0] g;

  always #5 clk_i = ~clk_i;

  deser_rr_arbiter #(
    .N_CH        (N_CH),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .req_i      (req_i),
    .data_i     (data_i),
    .data_val_i (data_val_i),
    .gnt_o      (gnt_o),
    .word_o     (word_o),
    .word_ch_o  (word_ch_o),
    .word_val_o (word_val_o),
    .err_o      (err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every emitted word must match the oldest expectation
  always @(negedge clk_i) begin
    if (!arst_i && word_val_o) begin
      words_seen++;
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("word", 64'(word_o), 64'(mon_e.w));
        check("word_ch", 64'(word_ch_o), 64'(mon_e.ch));
      end
    end
  end

  task automatic wait_grant(input logic [1:0] exp_ch, output logic [1:0] gch);
    bit seen;
    seen = 1'b0;
    gch  = exp_ch;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      if (gnt_o != 4'd0) seen = 1'b1;
    end
    check("grant_seen", 64'(seen), 64'd1);
    check("gnt_onehot", 64'(gnt_o), 64'd1 << exp_ch);
    for (int j = 0; j < N_CH; j++) begin
      if (gnt_o[2'(j)]) gch = 2'(j);
    end
  endtask

  task automatic send_bits(input logic [1:0] ch, input logic [15:0] w, input int nbits,
                           input bit noise, input bit gap);
    logic [15:0] sh;
    sh = w;
    for (int k = 0; k < nbits; k++) begin
      data_i[ch]     = sh[15];
      data_val_i[ch] = 1'b1;
      sh             = sh << 1;
      if (noise) begin
        for (int j = 0; j < N_CH; j++) begin
          if (2'(j) != ch) begin
            data_i[2'(j)]     = 1'($urandom);
            data_val_i[2'(j)] = 1'($urandom);
          end
        end
      end
      @(negedge clk_i);
      if (k != nbits - 1) check("no_early_val", 64'(word_val_o), 64'd0);
      if (gap && (k % 4 == 3) && (k != nbits - 1)) begin
        data_val_i[ch] = 1'b0;
        @(negedge clk_i);
      end
    end
    data_val_i = 4'd0;
  endtask

  task automatic serve_word(input logic [1:0] exp_ch, input logic [15:0] w,
                            input bit noise, input bit gap);
    logic [1:0] gch;
    exp_t e;
    wait_grant(exp_ch, gch);
    e.ch = exp_ch;
    e.w  = w;
    sb.push_back(e);
    words_pushed++;
    send_bits(gch, w, 16, noise, gap);
    check("word_val_pulse", 64'(word_val_o), 64'd1);
    check("gnt_clear_emit", 64'(gnt_o), 64'd0);
  endtask

  initial begin
    // Reset state
    @(negedge clk_i);
    check("rst_gnt", 64'(gnt_o), 64'd0);
    check("rst_val", 64'(word_val_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_word", 64'(word_o), 64'd0);
    check("rst_ch", 64'(word_ch_o), 64'd0);
    @(negedge clk_i);
    arst_i = 1'b0;

    // Single requester on channel 2, gap-free word
    req_i = 4'b0100;
    serve_word(2'd2, 16'hA5C3, 1'b0, 1'b0);
    req_i = 4'd0;
    @(negedge clk_i);
    check("val_single_cycle", 64'(word_val_o), 64'd0);
    check("gnt_idle", 64'(gnt_o), 64'd0);

    // Reset again so the pointer restarts at 0
    arst_i = 1'b1;
    @(negedge clk_i);
    arst_i = 1'b0;

    // Channels 0, 1, 3 continuously requesting: order 0, 1, 3, 0
    req_i = 4'b1011;
    serve_word(2'd0, 16'h0F0F, 1'b0, 1'b0);
    serve_word(2'd1, 16'h8001, 1'b0, 1'b0);
    serve_word(2'd3, 16'h3C96, 1'b0, 1'b0);
    serve_word(2'd0, 16'hFFFE, 1'b0, 1'b0);
    req_i = 4'd0;

    // Channel 1 granted while the other channels toggle noise, with gaps
    req_i = 4'b0010;
    serve_word(2'd1, 16'h1234, 1'b1, 1'b1);
    req_i = 4'd0;

    // Channel 3 withdraws after 7 bits; channel 0 is next
    req_i = 4'b1001;
    wait_grant(2'd3, g);
    send_bits(g, 16'hBEEF, 7, 1'b0, 1'b0);
    req_i[3] = 1'b0;
    @(negedge clk_i);
    check("abort_gnt", 64'(gnt_o), 64'd0);
    check("abort_val", 64'(word_val_o), 64'd0);
    check("abort_err", 64'(err_o), 64'd0);
    serve_word(2'd0, 16'h5AA5, 1'b0, 1'b0);
    req_i = 4'd0;

    // Asynchronous reset after 9 bits of channel 1
    req_i = 4'b0011;
    wait_grant(2'd1, g);
    send_bits(g, 16'hC0DE, 9, 1'b0, 1'b0);
    #2 arst_i = 1'b1;
    #1;
    check("arst_gnt", 64'(gnt_o), 64'd0);
    check("arst_val", 64'(word_val_o), 64'd0);
    check("arst_err", 64'(err_o), 64'd0);
    check("arst_word", 64'(word_o), 64'd0);
    check("arst_ch", 64'(word_ch_o), 64'd0);
    @(negedge clk_i);
    arst_i = 1'b0;
    serve_word(2'd0, 16'h7E81, 1'b0, 1'b0);
    req_i = 4'd0;

    // Channel 2 stalls after 3 bits
    req_i = 4'b0100;
    wait_grant(2'd2, g);
    send_bits(g, 16'hFFFF, 3, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
      @(negedge clk_i);
      check("stall_err_low", 64'(err_o), 64'd0);
      check("stall_gnt", 64'(gnt_o), 64'b0100);
    end
    @(negedge clk_i);
`ifdef DESER_RR_ARBITER_TIMEOUT_EN
    check("timeout_err", 64'(err_o), 64'd1);
    check("timeout_gnt", 64'(gnt_o), 64'd0);
`else
    check("no_timeout_err", 64'(err_o), 64'd0);
    check("no_timeout_gnt", 64'(gnt_o), 64'b0100);
`endif
    req_i = 4'd0;
    @(negedge clk_i);
    check("post_stall_err", 64'(err_o), 64'd0);
    check("post_stall_gnt", 64'(gnt_o), 64'd0);
    check("post_stall_val", 64'(word_val_o), 64'd0);

    repeat (3) @(negedge clk_i);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("word_count", 64'(words_seen), 64'(words_pushed));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound on total run time
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
